// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM encoding and access-legality helper for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Illegal width code for the direction, or an address not aligned to the access width.
  function automatic logic lsu_access_err(input logic store, input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    if (store) begin
      if ((funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W)) err = 1'b1;
      else err = err;
    end else begin
      if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)) err = 1'b1;
      else err = err;
    end
    case (funct3)
      F3_H, F3_HU: if (addr_lo[0]) err = 1'b1; else err = err;
      F3_W:        if (addr_lo != 2'b00) err = 1'b1; else err = err;
      default:     err = err;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane extraction with sign/zero extension for loads, and sub-word merge for stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] load_word,
  input  logic [31:0] store_word,
  input  logic [15:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Select the addressed lane and extend it to 32 bits.
  always_comb begin
    lane_byte = load_word[{addr_lo, 3'b000} +: 8];
    lane_half = load_word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_data = {24'h000000, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_data = {16'h0000, lane_half};
      F3_W:    load_data = load_word;
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Overwrite only the addressed byte/halfword of the previously read word.
  always_comb begin
    merged_word = store_word;
    case (funct3)
      F3_B:    merged_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
      F3_H:    merged_word[{addr_lo[1], 4'b0000} +: 16] = store_data;
      default: merged_word = store_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit on a word-wide data memory; sub-word stores are read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [MEM_AW-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state, next_state;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [MEM_AW-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_buf;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;
  logic              accept;
  logic              req_err;

  assign accept  = req_valid && (state == IDLE);
  assign req_err = lsu_access_err(req_store, req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .funct3      (funct3_q),
    .addr_lo     (addr_q[1:0]),
    .load_word   (mem_rdata),
    .store_word  (word_buf),
    .store_data  (wdata_q[15:0]),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: errors respond directly, word stores skip the read phase.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!accept)              next_state = IDLE;
        else if (req_err)         next_state = RESP;
        else if (!req_store)      next_state = RD;
        else if (req_funct3 == F3_W) next_state = WR;
        else                      next_state = RD;
      end
      RD:      next_state = store_q ? WR : RESP;
      WR:      next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake and memory-port drive; the write is suppressed while reset is asserted.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = 32'h0000_0000;
    case (state)
      RD: mem_addr = {addr_q[MEM_AW-1:2], 2'b00};
      WR: begin
        mem_addr  = {addr_q[MEM_AW-1:2], 2'b00};
        mem_we    = ~rst;
        mem_wdata = (funct3_q == F3_W) ? wdata_q : merged_word;
      end
      default: mem_addr = '0;
    endcase
  end

  // Request latches, read buffer and registered response payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_q    <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'h0000_0000;
      word_buf   <= 32'h0000_0000;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        store_q  <= req_store;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state == RD) word_buf <= mem_rdata;
      else             word_buf <= word_buf;
      resp_rdata <= ((state == RD) && !store_q) ? load_data : 32'h0000_0000;
      resp_err   <= accept && req_err;
    end
  end

endmodule
